// File: rtl/single_pc_fetch.sv
// Single-outstanding instruction fetch unit: one memory request at a time,
// one held instruction for decode, with branch/jump redirect handling.
module single_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus_1
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] addr_reg;
    logic [31:0] inst_reg;
    logic [31:0] inst_pc_reg;
    logic [31:0] pc_plus_1;

    assign pc_plus_1 = pc_reg + 32'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            pc_reg      <= RESET_PC;
            addr_reg    <= RESET_PC;
            inst_reg    <= 32'd0;
            inst_pc_reg <= 32'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (i_redirect)
                        pc_reg <= i_redirect_pc;
                    state_reg <= S_FETCH;
                end
                S_FETCH: begin
                    // Captured every cycle so a redirect can keep presenting
                    // the address of the request still in flight.
                    addr_reg <= pc_reg;
                    if (i_redirect) begin
                        pc_reg    <= i_redirect_pc;
                        state_reg <= i_imem_ack ? S_FETCH : S_DROP;
                    end else if (i_imem_ack) begin
                        inst_reg    <= i_imem_data;
                        inst_pc_reg <= pc_reg;
                        pc_reg      <= pc_plus_1;
                        state_reg   <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (i_redirect) begin
                        pc_reg    <= i_redirect_pc;
                        state_reg <= S_FETCH;
                    end else if (i_inst_ready) begin
                        state_reg <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (i_redirect)
                        pc_reg <= i_redirect_pc;
                    if (i_imem_ack)
                        state_reg <= S_FETCH;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign o_imem_req   = (state_reg == S_FETCH) || (state_reg == S_DROP);
    assign o_imem_addr  = (state_reg == S_FETCH) ? pc_reg : addr_reg;
    assign o_inst_valid = (state_reg == S_VALID);
    assign o_inst       = inst_reg;
    assign o_inst_pc    = inst_pc_reg;
    assign o_pc         = pc_reg;
    assign o_pc_plus_1  = pc_plus_1;

endmodule

// File: tb/tb_single_pc_fetch.sv
// Directed bench for single_pc_fetch: hand-computed expectations checked
// one microsecond-free cycle at a time, 1 time unit after each rising edge.
`timescale 1ns/1ps
module tb_single_pc_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus_1;

    int n_vec = 0;
    int n_bad = 0;

    single_pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_data   (i_imem_data),
        .o_inst_valid  (o_inst_valid),
        .i_inst_ready  (i_inst_ready),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .o_pc          (o_pc),
        .o_pc_plus_1   (o_pc_plus_1)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = 32'd0;
        i_imem_ack = 1'b0; i_imem_data = 32'd0; i_inst_ready = 1'b0;
        tick(); tick();
        check_val("rst_req",   32'(o_imem_req), 32'd0);
        check_val("rst_valid", 32'(o_inst_valid), 32'd0);
        check_val("rst_pc",    o_pc, 32'h0);
        check_val("rst_pc1",   o_pc_plus_1, 32'h1);
        check_val("rst_inst",  o_inst, 32'h0);

        // Release; the first edge moves IDLE -> FETCH.
        i_rst = 1'b0;
        tick();
        check_val("f0_req",  32'(o_imem_req), 32'd1);
        check_val("f0_addr", o_imem_addr, 32'h0);

        i_imem_ack = 1'b1; i_imem_data = 32'hAAAA_0001;
        tick();
        i_imem_ack = 1'b0;
        check_val("v0_valid", 32'(o_inst_valid), 32'd1);
        check_val("v0_inst",  o_inst, 32'hAAAA_0001);
        check_val("v0_ipc",   o_inst_pc, 32'h0);
        check_val("v0_pc",    o_pc, 32'h1);
        check_val("v0_pc1",   o_pc_plus_1, 32'h2);

        // Stall decode for five cycles; a stray ack in S_VALID is ignored.
        for (int k = 0; k < 5; k++) begin
            i_imem_ack  = (k == 2);
            i_imem_data = 32'hDEAD_BEEF;
            tick();
            check_val($sformatf("stall%0d_inst", k), o_inst, 32'hAAAA_0001);
            check_val($sformatf("stall%0d_pc", k),   o_pc, 32'h1);
            check_val($sformatf("stall%0d_req", k),  32'(o_imem_req), 32'd0);
            check_val($sformatf("stall%0d_ipc", k),  o_inst_pc, 32'h0);
        end
        i_imem_ack = 1'b0;

        i_inst_ready = 1'b1;
        tick();
        i_inst_ready = 1'b0;
        check_val("f1_valid", 32'(o_inst_valid), 32'd0);
        check_val("f1_addr",  o_imem_addr, 32'h1);

        // Redirect in FETCH without ack: drop phase keeps the old address.
        i_redirect = 1'b1; i_redirect_pc = 32'h0000_0100;
        tick();
        i_redirect = 1'b0;
        check_val("d0_req",  32'(o_imem_req), 32'd1);
        check_val("d0_addr", o_imem_addr, 32'h1);
        check_val("d0_pc",   o_pc, 32'h100);
        tick(); tick();
        check_val("d2_addr",  o_imem_addr, 32'h1);
        check_val("d2_valid", 32'(o_inst_valid), 32'd0);
        i_imem_ack = 1'b1; i_imem_data = 32'hBBBB_BBBB;
        tick();
        i_imem_ack = 1'b0;
        check_val("d3_valid", 32'(o_inst_valid), 32'd0);
        check_val("d3_addr",  o_imem_addr, 32'h100);
        tick();
        check_val("d4_valid", 32'(o_inst_valid), 32'd0);
        check_val("d4_addr",  o_imem_addr, 32'h100);

        // Fetch at 0x100, then redirect in VALID with ready in the same cycle.
        i_imem_ack = 1'b1; i_imem_data = 32'hC0DE_0100;
        tick();
        i_imem_ack = 1'b0;
        check_val("v1_inst", o_inst, 32'hC0DE_0100);
        check_val("v1_ipc",  o_inst_pc, 32'h100);
        check_val("v1_pc",   o_pc, 32'h101);
        i_redirect = 1'b1; i_redirect_pc = 32'h40; i_inst_ready = 1'b1;
        tick();
        i_redirect = 1'b0; i_inst_ready = 1'b0;
        check_val("r1_valid", 32'(o_inst_valid), 32'd0);
        check_val("r1_addr",  o_imem_addr, 32'h40);

        // Redirect with same-cycle ack: data discarded, refetch at target.
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFF;
        i_imem_ack = 1'b1; i_imem_data = 32'h1234_5678;
        tick();
        i_redirect = 1'b0;
        check_val("r2_valid", 32'(o_inst_valid), 32'd0);
        check_val("r2_addr",  o_imem_addr, 32'hFFFF_FFFF);
        check_val("r2_pc1",   o_pc_plus_1, 32'h0);
        i_imem_data = 32'h5555_FFFF;
        tick();
        i_imem_ack = 1'b0;
        check_val("w_valid", 32'(o_inst_valid), 32'd1);
        check_val("w_inst",  o_inst, 32'h5555_FFFF);
        check_val("w_ipc",   o_inst_pc, 32'hFFFF_FFFF);
        check_val("w_pc",    o_pc, 32'h0);
        check_val("w_pc1",   o_pc_plus_1, 32'h1);

        i_inst_ready = 1'b1;
        tick();
        i_inst_ready = 1'b0;
        check_val("f2_addr", o_imem_addr, 32'h0);

        // Enter DROP, redirect again inside DROP, then reset asynchronously.
        i_redirect = 1'b1; i_redirect_pc = 32'h200;
        tick();
        i_redirect_pc = 32'h300;
        tick();
        i_redirect = 1'b0;
        check_val("dd_pc",   o_pc, 32'h300);
        check_val("dd_addr", o_imem_addr, 32'h0);
        check_val("dd_req",  32'(o_imem_req), 32'd1);
        #2 i_rst = 1'b1;
        #1;
        check_val("ar_req",  32'(o_imem_req), 32'd0);
        check_val("ar_pc",   o_pc, 32'h0);
        check_val("ar_addr", o_imem_addr, 32'h0);
        check_val("ar_inst", o_inst, 32'h0);
        check_val("ar_ipc",  o_inst_pc, 32'h0);

        // Reset dominates every other input.
        i_redirect = 1'b1; i_redirect_pc = 32'h777; i_imem_ack = 1'b1; i_inst_ready = 1'b1;
        tick(); tick();
        check_val("rh_pc",    o_pc, 32'h0);
        check_val("rh_req",   32'(o_imem_req), 32'd0);
        check_val("rh_valid", 32'(o_inst_valid), 32'd0);
        i_redirect = 1'b0; i_imem_ack = 1'b0; i_inst_ready = 1'b0;
        i_rst = 1'b0;
        tick();
        check_val("rr_req",  32'(o_imem_req), 32'd1);
        check_val("rr_addr", o_imem_addr, 32'h0);

        // Redirect in IDLE still loads the PC.
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h80;
        tick();
        i_redirect = 1'b0;
        check_val("idle_req",  32'(o_imem_req), 32'd1);
        check_val("idle_addr", o_imem_addr, 32'h80);
        check_val("idle_pc",   o_pc, 32'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100us");
        $fatal(1);
    end

endmodule

// File: doc/single_pc_fetch.md
SINGLE_PC_FETCH -- requirements
Module: single_pc_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, word address loaded into the PC on reset.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  reset, asynchronous and active-high.
REQ-004 i_redirect  input  1  one-cycle request to load a taken branch/jump target.
REQ-005 i_redirect_pc  input  32  target word address, valid when i_redirect=1.
REQ-006 o_imem_req  output  1  instruction-memory read request.
REQ-007 o_imem_addr  output  32  word address of the outstanding request.
REQ-008 i_imem_ack  input  1  memory response strobe; data valid in the same cycle.
REQ-009 i_imem_data  input  32  instruction word, valid when i_imem_ack=1.
REQ-010 o_inst_valid  output  1  a fetched instruction is held for decode.
REQ-011 i_inst_ready  input  1  decode accepts the held instruction this cycle.
REQ-012 o_inst  output  32  held instruction word.
REQ-013 o_inst_pc  output  32  word address of o_inst.
REQ-014 o_pc  output  32  current PC register value.
REQ-015 o_pc_plus_1  output  32  o_pc + 1, modulo 2^32 (word-addressed increment).

Function
REQ-016 The FSM shall have exactly four states: S_IDLE, S_FETCH, S_VALID and S_DROP.
REQ-017 o_imem_req shall be 1 in S_FETCH and S_DROP, and 0 otherwise; o_inst_valid shall be 1 only in S_VALID.
REQ-018 S_IDLE shall transition to S_FETCH unconditionally on the next edge.
REQ-019 In S_FETCH, o_imem_addr shall equal the PC, and an internal address register shall capture the PC every cycle.
REQ-020 S_FETCH with i_imem_ack=1 and i_redirect=0 shall latch o_inst<=i_imem_data and o_inst_pc<=PC, set PC<=PC+1 (wrap 32'hFFFF_FFFF->0), and go to S_VALID (ack in cycle N -> o_inst_valid in N+1).
REQ-021 S_FETCH without ack shall hold the state, the PC and the address.
REQ-022 In S_VALID, o_inst and o_inst_pc shall hold stable until i_inst_ready=1; a handshake shall go to S_FETCH, so the peak rate is one instruction per 2 cycles.
REQ-023 i_redirect shall have the highest priority in every state except S_IDLE, always setting PC<=i_redirect_pc.
REQ-024 Redirect in S_FETCH with same-cycle ack: data discarded; next state S_FETCH at the new PC.
REQ-025 Redirect in S_FETCH without ack: next state S_DROP; o_imem_addr shall stay at the old captured address while o_imem_req=1.
REQ-026 In S_DROP, an ack shall discard i_imem_data and go to S_FETCH, and a further redirect shall update the PC and stay in S_DROP if no ack is present.
REQ-027 Redirect in S_VALID: held instruction discarded (o_inst_valid=0 next cycle even if i_inst_ready=1); next state S_FETCH.
REQ-028 i_redirect in S_IDLE shall still load the PC, and the FSM shall go to S_FETCH.
REQ-029 o_pc_plus_1 shall be combinational from the PC register, with no registering.
REQ-030 i_imem_ack shall be ignored in S_IDLE and S_VALID.

Reset
REQ-031 Asserting i_rst shall immediately (asynchronously) force: state=S_IDLE, PC=RESET_PC, o_inst=0, o_inst_pc=0, address register=RESET_PC; hence o_imem_req=0 and o_inst_valid=0.
REQ-032 Reset mid-request shall abandon any outstanding request without a drop phase; the first request after release shall be to RESET_PC, one cycle after the first edge with i_rst=0.
REQ-033 Nothing shall change while i_rst=1 regardless of other inputs.

Verification
REQ-034 Reset, then ack with data 32'hAAAA_0001 on the first request -> o_imem_addr=0; one cycle later o_inst_valid=1, o_inst=32'hAAAA_0001, o_inst_pc=0, o_pc=1, o_pc_plus_1=2.
REQ-035 Hold i_inst_ready=0 for 5 cycles with o_inst_valid=1 -> o_inst, o_inst_pc and o_pc stable and o_imem_req=0; raise i_inst_ready -> next request at addr 1.
REQ-036 Redirect to 32'h0000_0100 in S_FETCH, no ack for 3 cycles -> o_imem_addr stays at the old address; on ack, data is dropped (o_inst_valid stays 0); next request at 32'h100.
REQ-037 Redirect to 32'h40 in S_VALID with i_inst_ready=1 in the same cycle -> instruction dropped; next request at 32'h40.
REQ-038 Redirect to 32'hFFFF_FFFF, then ack -> o_inst_pc=32'hFFFF_FFFF and o_pc=0 (wrap).
REQ-039 Assert i_rst asynchronously mid-S_DROP -> outputs reach reset values before the next edge; after release, the request goes to RESET_PC.
